// File: rtl/mem_arbiter_if.sv
// Shared-memory arbiter bus: data and fetch request/response
// channels plus the single memory port and lock abort strobe.
interface mem_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             d_req_valid;
    logic             d_req_ready;
    logic             d_req_we;
    logic             d_req_lock;
    logic [WIDTH-1:0] d_req_addr;
    logic [31:0]      d_req_wdata;
    logic             d_rsp_valid;
    logic [31:0]      d_rsp_rdata;
    logic             i_req_valid;
    logic             i_req_ready;
    logic [WIDTH-1:0] i_req_addr;
    logic             i_rsp_valid;
    logic [31:0]      i_rsp_rdata;
    logic             mem_wr_en;
    logic [WIDTH-1:0] mem_addr;
    logic [31:0]      mem_wr_data;
    logic [31:0]      mem_rd_data;
    logic             lock_abort;

    modport master (
        output d_req_valid, d_req_we, d_req_lock,
        output d_req_addr, d_req_wdata,
        output i_req_valid, i_req_addr,
        output mem_rd_data,
        input  d_req_ready, d_rsp_valid, d_rsp_rdata,
        input  i_req_ready, i_rsp_valid, i_rsp_rdata,
        input  mem_wr_en, mem_addr, mem_wr_data,
        input  lock_abort
    );

    modport slave (
        input  d_req_valid, d_req_we, d_req_lock,
        input  d_req_addr, d_req_wdata,
        input  i_req_valid, i_req_addr,
        input  mem_rd_data,
        output d_req_ready, d_rsp_valid, d_rsp_rdata,
        output i_req_ready, i_rsp_valid, i_rsp_rdata,
        output mem_wr_en, mem_addr, mem_wr_data,
        output lock_abort
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (data/fetch) arbiter onto one memory, with data-side lock.
// MEM_ARB_RR_EN selects round-robin; otherwise data has fixed priority.
module mem_arbiter #(
    parameter int DEPTH    = 256,
    parameter int WIDTH    = $clog2(DEPTH),
    parameter int LOCK_MAX = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t     state;
    logic [7:0] cnt;
    logic       d_pri;
    logic       d_gnt;
    logic       i_gnt;
    logic       timeout;

`ifdef MEM_ARB_RR_EN
    logic last_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d <= 1'b0;
        end else if (d_gnt || i_gnt) begin
            last_d <= d_gnt;
        end
    end

    assign d_pri = !last_d;
`else
    assign d_pri = 1'b1;
`endif

    // Contention only matters in IDLE; a lock owner takes every request.
    always_comb begin
        d_gnt = 1'b0;
        i_gnt = 1'b0;
        if (state == LOCKED) begin
            d_gnt = bus.d_req_valid;
        end else begin
            d_gnt = bus.d_req_valid && (!bus.i_req_valid || d_pri);
            i_gnt = bus.i_req_valid && !d_gnt;
        end
    end

    assign timeout = (state == LOCKED) && !d_gnt && (cnt == 8'(LOCK_MAX));

    assign bus.d_req_ready = d_gnt;
    assign bus.i_req_ready = i_gnt;
    assign bus.mem_wr_en   = d_gnt && bus.d_req_we;
    assign bus.mem_wr_data = d_gnt ? bus.d_req_wdata : 32'd0;

    always_comb begin
        bus.mem_addr = '0;
        if (d_gnt) begin
            bus.mem_addr = bus.d_req_addr;
        end else if (i_gnt) begin
            bus.mem_addr = bus.i_req_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= 8'd0;
            bus.d_rsp_valid <= 1'b0;
            bus.d_rsp_rdata <= 32'd0;
            bus.i_rsp_valid <= 1'b0;
            bus.i_rsp_rdata <= 32'd0;
            bus.lock_abort  <= 1'b0;
        end else begin
            bus.d_rsp_valid <= d_gnt;
            bus.i_rsp_valid <= i_gnt;
            bus.lock_abort  <= timeout;
            if (d_gnt) begin
                bus.d_rsp_rdata <= bus.d_req_we ? bus.d_req_wdata
                                                : bus.mem_rd_data;
            end
            if (i_gnt) begin
                bus.i_rsp_rdata <= bus.mem_rd_data;
            end
            unique case (state)
                IDLE: begin
                    cnt <= 8'd0;
                    if (d_gnt && bus.d_req_lock) begin
                        state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (d_gnt) begin
                        cnt <= 8'd0;
                        if (!bus.d_req_lock) begin
                            state <= IDLE;
                        end
                    end else if (timeout) begin
                        cnt   <= 8'd0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 8'd0;
                end
            endcase
        end
    end
endmodule
